mem_arb: RTL and testbench

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_pkg.sv | 40 ++++
 rtl/mem_arb_rr_pick3.sv | 37 +++
 rtl/mem_arb.sv | 146 ++++++++++++++
 tb/tb_mem_arb.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared definitions for the mem_arb memory-port arbiter:
//                FSM state encoding, requester index constants and small
//                round-robin helper functions.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_pkg;

  localparam int NUM_REQ = 3;

  // Requester indices
  localparam logic [1:0] REQ_FETCH = 2'd0;
  localparam logic [1:0] REQ_DATA  = 2'd1;
  localparam logic [1:0] REQ_STACK = 2'd2;

  // Arbiter FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;

  // Next requester index in round-robin order, wrapping 2 -> 0
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx == REQ_STACK) ? REQ_FETCH : idx + 2'd1;
  endfunction

  // Requester index to one-hot vector
  function automatic logic [NUM_REQ-1:0] idx_onehot(input logic [1:0] idx);
    logic [NUM_REQ-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (idx == i[1:0]) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_rr_pick3.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick3
//  Description : Three-way round-robin picker. Scans requesters starting at
//                rr_ptr and returns the first active one.
//  Ports       : req    - request vector (one bit per requester)
//                rr_ptr - index with highest priority this round
//                valid  - at least one request active
//                winner - index of the selected requester
//  Revision    : 1.0  initial release
// ============================================================================
module rr_pick3
  import mem_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         rr_ptr,
  output logic               valid,
  output logic [1:0]         winner
);

  logic [1:0] w_idx;

  always_comb begin
    valid  = 1'b0;
    winner = rr_ptr;
    w_idx  = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!valid && req[w_idx]) begin
        valid  = 1'b1;
        winner = w_idx;
      end
      w_idx = rr_next(w_idx);
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arb.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb
//  Description : Round-robin arbiter giving three requesters (fetch, data,
//                stack) access to one single-port memory with one cycle of
//                read latency. IDLE -> ISSUE (-> WAIT on reads) -> IDLE.
//  Ports       : clk, rst_n            - clock, async active-low reset
//                req/we/addr/wdata     - packed per-requester request bus
//                gnt, rvalid, rdata    - per-requester responses
//                mem_en/wen/addr/wdata - memory command, mem_rdata returned
//                busy                  - transaction in progress
//                err                   - write range violation pulse
//  Config      : MEM_ARB_RANGE_CHECK_EN - block writes above WR_LIMIT and
//                pulse err instead of enabling the memory.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arb
  import mem_pkg::*;
#(
  parameter int             AW       = 16,
  parameter int             DW       = 16,
  parameter logic [AW-1:0]  WR_LIMIT = AW'(16'hBFFF)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   we,
  input  logic [NUM_REQ*AW-1:0] addr,
  input  logic [NUM_REQ*DW-1:0] wdata,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   rvalid,
  output logic [DW-1:0]        rdata,
  output logic                 mem_en,
  output logic                 mem_wen,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  input  logic [DW-1:0]        mem_rdata,
  output logic                 busy,
  output logic                 err
);

  state_t        state_q, state_d;
  logic [1:0]    rr_ptr_q, rr_ptr_d;
  logic [1:0]    win_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;

  logic          w_pick_valid;
  logic [1:0]    w_pick_win;
  logic          w_sel_we;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;
  logic          w_latch;
  logic          w_issue;
  logic          w_wait;
  logic          w_range_err;

  rr_pick3 u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .valid  (w_pick_valid),
    .winner (w_pick_win)
  );

  // Steer the winner's request fields out of the packed buses
  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick_win == i[1:0]) begin
        w_sel_we    = we[i];
        w_sel_addr  = addr[i*AW +: AW];
        w_sel_wdata = wdata[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    w_latch  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_pick_valid) begin
          w_latch = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        rr_ptr_d = rr_next(win_q);
        state_d  = we_q ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= REQ_FETCH;
      win_q    <= REQ_FETCH;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      if (w_latch) begin
        win_q   <= w_pick_win;
        we_q    <= w_sel_we;
        addr_q  <= w_sel_addr;
        wdata_q <= w_sel_wdata;
      end
      if (w_wait) rdata_q <= mem_rdata;
    end
  end

  assign w_issue = (state_q == ST_ISSUE);
  assign w_wait  = (state_q == ST_WAIT);

`ifdef MEM_ARB_RANGE_CHECK_EN
  assign w_range_err = w_issue & we_q & (addr_q > WR_LIMIT);
`else
  logic w_unused_wr_limit;
  assign w_unused_wr_limit = ^WR_LIMIT;
  assign w_range_err       = 1'b0;
`endif

  assign gnt       = w_issue ? idx_onehot(win_q) : '0;
  assign rvalid    = w_wait  ? idx_onehot(win_q) : '0;
  // Memory data is live during WAIT; afterwards the captured copy is held
  assign rdata     = w_wait  ? mem_rdata : rdata_q;
  assign mem_en    = w_issue & ~w_range_err;
  assign mem_wen   = w_issue & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != ST_IDLE);
  assign err       = w_range_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arb
//  Description : Directed self-checking bench for mem_arb. A behavioural
//                memory returns mem_addr ^ 16'h3F12 one cycle after a read.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_arb;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req;
  logic [2:0]  we;
  logic [47:0] addr;
  logic [47:0] wdata;
  logic [2:0]  gnt;
  logic [2:0]  rvalid;
  logic [15:0] rdata;
  logic        mem_en;
  logic        mem_wen;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        busy;
  logic        err;

  int n_checks;
  int n_errors;

`ifdef MEM_ARB_RANGE_CHECK_EN
  localparam logic c_rc = 1'b1;
`else
  localparam logic c_rc = 1'b0;
`endif

  mem_arb u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory with one cycle of registered read latency
  initial mem_rdata = 16'h0000;
  always @(posedge clk) begin
    if (mem_en && !mem_wen) mem_rdata <= mem_addr ^ 16'h3F12;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sampling/driving happens 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  logic [2:0]  exp_order [4];
  logic [15:0] exp_rd    [4];

  initial begin
    n_checks = 0;
    n_errors = 0;
    req   = 3'b000;
    we    = 3'b000;
    addr  = '0;
    wdata = '0;
    rst_n = 1'b1;
    #2;

    // ---------------- reset state ----------------
    rst_n = 1'b0;
    #1;
    check("rst_gnt",    {29'd0, gnt},    32'd0);
    check("rst_rvalid", {29'd0, rvalid}, 32'd0);
    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("rst_busy",   {31'd0, busy},   32'd0);
    check("rst_rdata",  {16'd0, rdata},  32'd0);
    check("rst_maddr",  {16'd0, mem_addr}, 32'd0);
    check("rst_err",    {31'd0, err},    32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // ---------------- single fetch read ----------------
    req  = 3'b001;
    we   = 3'b000;
    addr = {16'h0000, 16'h0000, 16'h0100};
    tick();
    check("rd_gnt",    {29'd0, gnt},      32'h1);
    check("rd_mem_en", {31'd0, mem_en},   32'h1);
    check("rd_wen",    {31'd0, mem_wen},  32'h0);
    check("rd_maddr",  {16'd0, mem_addr}, 32'h0100);
    check("rd_busy",   {31'd0, busy},     32'h1);
    req = 3'b000;
    tick();
    check("rd_rvalid", {29'd0, rvalid},   32'h1);
    check("rd_rdata",  {16'd0, rdata},    32'h3E12);
    check("rd_gnt0",   {29'd0, gnt},      32'h0);
    check("rd_en0",    {31'd0, mem_en},   32'h0);
    tick();
    check("rd_rv_end", {29'd0, rvalid},   32'h0);
    check("rd_hold",   {16'd0, rdata},    32'h3E12);
    check("rd_idle",   {31'd0, busy},     32'h0);

    // ---------------- all three from reset, held ----------------
    do_reset();
    exp_order[0] = 3'b001; exp_rd[0] = 16'h3D12;
    exp_order[1] = 3'b010; exp_rd[1] = 16'h3C12;
    exp_order[2] = 3'b100; exp_rd[2] = 16'h3B12;
    exp_order[3] = 3'b001; exp_rd[3] = 16'h3D12;
    req  = 3'b111;
    we   = 3'b000;
    addr = {16'h0400, 16'h0300, 16'h0200};
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rr_gnt",    {29'd0, gnt},    {29'd0, exp_order[i]});
      tick();
      check("rr_rvalid", {29'd0, rvalid}, {29'd0, exp_order[i]});
      check("rr_rdata",  {16'd0, rdata},  {16'd0, exp_rd[i]});
      if (i == 3) req = 3'b000;
      tick();
    end
    // rr_ptr now 1

    // ---------------- stack write ----------------
    req   = 3'b100;
    we    = 3'b100;
    addr  = {16'hFFFE, 16'h0000, 16'h0000};
    wdata = {16'hABCD, 16'h0000, 16'h0000};
    tick();
    check("sw_gnt",    {29'd0, gnt},       32'h4);
    check("sw_mem_en", {31'd0, mem_en},    {31'd0, ~c_rc});
    check("sw_wen",    {31'd0, mem_wen},   32'h1);
    check("sw_wdata",  {16'd0, mem_wdata}, 32'hABCD);
    check("sw_err",    {31'd0, err},       {31'd0, c_rc});
    req = 3'b000;
    we  = 3'b000;
    tick();
    check("sw_idle",   {31'd0, busy},      32'h0);
    check("sw_norv",   {29'd0, rvalid},    32'h0);
    check("sw_err0",   {31'd0, err},       32'h0);
    // rr_ptr now 0

    // ---------------- data write above limit ----------------
    req   = 3'b010;
    we    = 3'b010;
    addr  = {16'h0000, 16'hC000, 16'h0000};
    wdata = {16'h0000, 16'h5A5A, 16'h0000};
    tick();
    check("dw_gnt",    {29'd0, gnt},    32'h2);
    check("dw_mem_en", {31'd0, mem_en}, {31'd0, ~c_rc});
    check("dw_err",    {31'd0, err},    {31'd0, c_rc});
    req = 3'b000;
    tick();
    check("dw_err_end", {31'd0, err},   32'h0);
    // rr_ptr now 2

    // ---------------- data write exactly at limit ----------------
    req  = 3'b010;
    addr = {16'h0000, 16'hBFFF, 16'h0000};
    tick();
    check("lim_gnt",    {29'd0, gnt},      32'h2);
    check("lim_mem_en", {31'd0, mem_en},   32'h1);
    check("lim_err",    {31'd0, err},      32'h0);
    check("lim_maddr",  {16'd0, mem_addr}, 32'hBFFF);
    req = 3'b000;
    we  = 3'b000;
    tick();
    // rr_ptr now 2

    // ---------------- pointer at 2, requesters 0 and 1 ----------------
    req  = 3'b011;
    addr = {16'h0000, 16'h0300, 16'h0100};
    tick();
    check("wrap_gnt", {29'd0, gnt}, 32'h1);
    req = 3'b000;
    tick();
    check("wrap_rd",  {16'd0, rdata}, 32'h3E12);
    tick();
    // rr_ptr now 1

    // ---------------- reset during WAIT ----------------
    req = 3'b010;
    tick();
    check("ab_gnt", {29'd0, gnt}, 32'h2);
    req = 3'b000;
    tick();
    check("ab_wait", {31'd0, busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("ab_rvalid", {29'd0, rvalid}, 32'h0);
    check("ab_busy",   {31'd0, busy},   32'h0);
    check("ab_rdata",  {16'd0, rdata},  32'h0);
    check("ab_maddr",  {16'd0, mem_addr}, 32'h0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ab_norv", {29'd0, rvalid | gnt}, 32'h0);
    end
    req = 3'b111;
    tick();
    check("ab_next_gnt", {29'd0, gnt}, 32'h1);
    req = 3'b000;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
